// File: rtl/volume_history_display.sv
// Scrolling volume-history bar graph: circular buffer of mic levels plus a decaying
// peak-hold marker, rendered as a registered RGB565 pixel for the requested (x,y).
module volume_history_display #(
    parameter int          NUM_COLS  = 16,
    parameter int          NUM_ROWS  = 16,
    parameter int          X0        = 43,
    parameter int          Y_BOT     = 52,
    parameter int          CELL_W    = 2,
    parameter int          CELL_H    = 2,
    parameter int          PITCH     = 3,
    parameter int          PEAK_HOLD = 8,
    parameter int          ROW_MID   = 10,
    parameter int          ROW_HI    = 13,
    parameter logic [15:0] C_BG      = 16'hFFFF,
    parameter logic [15:0] C_UNLIT   = 16'h0000,
    parameter logic [15:0] C_LO      = 16'h07E0,
    parameter logic [15:0] C_MID     = 16'hFFE0,
    parameter logic [15:0] C_HI      = 16'hF800,
    parameter logic [15:0] C_PEAK    = 16'h001F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [4:0]  level_in,
    input  logic        freeze,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [4:0]  peak_level
);

    localparam int PTR_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int HOLD_W = $clog2(PEAK_HOLD + 1);

    localparam logic [4:0]        MAX_LEVEL = 5'(NUM_ROWS);
    localparam logic [4:0]        ROW_MID_L = 5'(ROW_MID);
    localparam logic [4:0]        ROW_HI_L  = 5'(ROW_HI);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PEAK_HOLD);

    logic [4:0]        hist [NUM_COLS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [4:0]        peak;
    logic [HOLD_W-1:0] hold_cnt;

    logic              accept;
    logic [4:0]        level_sat;

    logic [7:0]        x8;
    logic [7:0]        y8;
    int                x_pos;
    int                y_pos;

    logic              col_hit;
    logic              row_hit;
    logic [PTR_W-1:0]  col_idx;
    logic [PTR_W-1:0]  rd_idx;
    logic [4:0]        row_idx;
    logic [4:0]        col_h;
    logic [4:0]        peak_row;
    logic [15:0]       pixel;

    assign accept    = sample_tick & ~freeze;
    assign level_sat = (level_in > MAX_LEVEL) ? MAX_LEVEL : level_in;

    // History write and peak-hold decay both advance only on an accepted tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                hist[i] <= '0;
            end
            wr_ptr   <= '0;
            peak     <= '0;
            hold_cnt <= '0;
        end else if (accept) begin
            hist[wr_ptr] <= level_sat;
            wr_ptr       <= wr_ptr + 1'b1;
            if (level_sat >= peak) begin
                peak     <= level_sat;
                hold_cnt <= HOLD_INIT;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end else if (peak != '0) begin
                peak <= peak - 1'b1;
            end
        end
    end

    // Coordinates are compared as signed ints so a cell edge that would fall
    // left of / below the screen never wraps around.
    assign x8    = {1'b0, x};
    assign y8    = {2'b0, y};
    assign x_pos = int'(x8);
    assign y_pos = int'(y8);

    always_comb begin
        col_hit = 1'b0;
        col_idx = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (x_pos >= X0 + c * PITCH && x_pos <= X0 + c * PITCH + CELL_W - 1) begin
                col_hit = 1'b1;
                col_idx = PTR_W'(c);
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (y_pos >= Y_BOT - r * PITCH - CELL_H + 1 && y_pos <= Y_BOT - r * PITCH) begin
                row_hit = 1'b1;
                row_idx = 5'(r);
            end
        end
    end

    // Display column 0 is the oldest entry, i.e. the slot about to be overwritten.
    assign rd_idx   = wr_ptr + col_idx;
    assign col_h    = hist[rd_idx];
    assign peak_row = peak - 5'd1;

    always_comb begin
        pixel = C_BG;
        if (col_hit && row_hit) begin
            if (row_idx < col_h) begin
                if (row_idx < ROW_MID_L) begin
                    pixel = C_LO;
                end else if (row_idx < ROW_HI_L) begin
                    pixel = C_MID;
                end else begin
                    pixel = C_HI;
                end
            end else if (peak != '0 && row_idx == peak_row) begin
                pixel = C_PEAK;
            end else begin
                pixel = C_UNLIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oled_data <= C_BG;
        end else begin
            oled_data <= pixel;
        end
    end

    assign peak_level = peak;

endmodule
